// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of CPU inst/data request channels and the shared memory port.
// The slave modport is the arbiter's view; the master modport drives the CPU and memory sides.
interface cpu_mem_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wdata, err
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Merges CPU inst/data channels onto one memory port, tracking response order in a tag FIFO.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over inst.
module cpu_mem_arbiter #(
  parameter int unsigned OUTSTANDING = 4
) (
  input logic              clk,
  input logic              reset,
  cpu_mem_arbiter_if.slave bus
);

  localparam int unsigned PtrW = $clog2(OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic SrcInst = 1'b0;
  localparam logic SrcData = 1'b1;

  logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [OUTSTANDING-1:0] tag_q, tag_d;
  logic                   lock_q, lock_d;
  logic                   lock_src_q, lock_src_d;
  logic                   err_q, err_d;
`ifdef ARB_RR_EN
  logic                   last_src_q, last_src_d;
`endif

  logic full, empty, gnt, offer, accept, pop, head_tag;

  assign full     = (cnt_q == CntW'(OUTSTANDING));
  assign empty    = (cnt_q == '0);
  assign head_tag = tag_q[rptr_q];

  // A locked grant keeps the offered channel until memory accepts it.
  always_comb begin
    gnt = SrcInst;
    if (lock_q) begin
      gnt = lock_src_q;
    end else if (bus.inst_req && bus.data_req) begin
`ifdef ARB_RR_EN
      gnt = ~last_src_q;
`else
      gnt = SrcData;
`endif
    end else if (bus.data_req) begin
      gnt = SrcData;
    end
  end

  assign offer  = (bus.inst_req | bus.data_req) & ~full & ~reset;
  assign accept = offer & bus.mem_addr_ok;
  assign pop    = bus.mem_data_ok & ~empty & ~reset;

  assign bus.mem_req      = offer;
  assign bus.mem_wr       = offer & gnt & bus.data_wr;
  assign bus.mem_size     = offer ? (gnt ? bus.data_size : 2'd2) : 2'd0;
  assign bus.mem_addr     = offer ? (gnt ? bus.data_addr : bus.inst_addr) : 32'd0;
  assign bus.mem_wdata    = (offer & gnt) ? bus.data_wdata : 32'd0;
  assign bus.inst_addr_ok = accept & ~gnt;
  assign bus.data_addr_ok = accept & gnt;
  assign bus.inst_data_ok = pop & ~head_tag;
  assign bus.data_data_ok = pop & head_tag;
  assign bus.rdata        = bus.mem_rdata;
  assign bus.err          = err_q & ~reset;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    tag_d      = tag_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    err_d      = err_q;
`ifdef ARB_RR_EN
    last_src_d = last_src_q;
`endif
    if (accept) begin
      tag_d[wptr_q] = gnt;
      wptr_d        = wptr_q + PtrW'(1);
      lock_d        = 1'b0;
`ifdef ARB_RR_EN
      last_src_d    = gnt;
`endif
    end else if (offer) begin
      lock_d     = 1'b1;
      lock_src_d = gnt;
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (bus.mem_data_ok && empty) begin
      err_d = 1'b1;
    end
    cnt_d = cnt_q + CntW'(accept) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= SrcInst;
      err_q      <= 1'b0;
`ifdef ARB_RR_EN
      last_src_q <= SrcInst;
`endif
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      err_q      <= err_d;
`ifdef ARB_RR_EN
      last_src_q <= last_src_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus random traffic, all checked each cycle
// against a queue-based model of the arbitration and in-order response rules.
module tb_cpu_mem_arbiter;

  localparam int unsigned Outstanding = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_mem_arbiter_if bus ();

  cpu_mem_arbiter #(.OUTSTANDING(Outstanding)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queue of source tags (0 inst, 1 data) in acceptance order.
  bit tagq[$];
  bit err_m      = 0;
  bit lock_m     = 0;
  bit lock_src_m = 0;
  bit last_m     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs applied; checks this cycle and advances the model.
  task automatic step();
    bit ir, dr, g, ereq, eacc, epop, etag, was_empty;
    #1;
    ir = bus.inst_req;
    dr = bus.data_req;
    if (lock_m) g = lock_src_m;
    else if (ir && dr) begin
`ifdef ARB_RR_EN
      g = !last_m;
`else
      g = 1'b1;
`endif
    end else g = dr;
    was_empty = (tagq.size() == 0);
    ereq = !reset && (ir || dr) && (tagq.size() < Outstanding);
    eacc = ereq && bus.mem_addr_ok;
    epop = !reset && bus.mem_data_ok && !was_empty;
    etag = epop ? tagq[0] : 1'b0;

    check("mem_req", 32'(bus.mem_req), 32'(ereq));
    check("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(eacc && !g));
    check("data_addr_ok", 32'(bus.data_addr_ok), 32'(eacc && g));
    check("inst_data_ok", 32'(bus.inst_data_ok), 32'(epop && !etag));
    check("data_data_ok", 32'(bus.data_data_ok), 32'(epop && etag));
    check("err", 32'(bus.err), 32'(!reset && err_m));
    if (ereq) begin
      check("mem_addr", bus.mem_addr, g ? bus.data_addr : bus.inst_addr);
      check("mem_wr", 32'(bus.mem_wr), g ? 32'(bus.data_wr) : 32'd0);
      check("mem_size", 32'(bus.mem_size), g ? 32'(bus.data_size) : 32'd2);
      if (g) check("mem_wdata", bus.mem_wdata, bus.data_wdata);
    end
    if (epop) check("rdata", bus.rdata, bus.mem_rdata);

    if (reset) begin
      tagq.delete();
      err_m = 0; lock_m = 0; lock_src_m = 0; last_m = 0;
    end else begin
      if (epop) void'(tagq.pop_front());
      if (bus.mem_data_ok && was_empty) err_m = 1;
      if (eacc) begin
        tagq.push_back(g);
        last_m = g;
        lock_m = 0;
      end else if (ereq) begin
        lock_m = 1;
        lock_src_m = g;
      end
    end
    @(negedge clk);
    if (eacc && !g) bus.inst_req = 1'b0;
    if (eacc && g)  bus.data_req = 1'b0;
  endtask

  task automatic drain();
    bus.mem_addr_ok = 1'b0;
    for (int i = 0; i < 20 && tagq.size() > 0; i++) begin
      bus.mem_data_ok = 1'b1;
      bus.mem_rdata   = $urandom;
      step();
    end
    bus.mem_data_ok = 1'b0;
    check("drain_empty", 32'(tagq.size()), 32'd0);
  endtask

  task automatic put_data(input bit wr, input logic [31:0] addr);
    bus.data_req   = 1'b1;
    bus.data_wr    = wr;
    bus.data_size  = 2'($urandom_range(0, 2));
    bus.data_addr  = addr;
    bus.data_wdata = $urandom;
  endtask

  initial begin
    reset = 1'b1;
    bus.inst_req = 0; bus.inst_addr = 0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_addr = 0; bus.data_wdata = 0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = 0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Single inst read, response two cycles after acceptance.
    bus.inst_req = 1; bus.inst_addr = 32'h1c00_0000; bus.mem_addr_ok = 1;
    step();
    bus.mem_addr_ok = 0;
    step();
    bus.mem_data_ok = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    check("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
    bus.mem_data_ok = 0;
    step();

    // Simultaneous inst and data requests.
    bus.inst_req = 1; bus.inst_addr = 32'h0000_1000;
    put_data(1'b0, 32'h0000_2000);
    bus.mem_addr_ok = 1;
    step();
    step();
    drain();

    // Lock: inst offered but stalled, data arrives mid-offer.
    bus.mem_addr_ok = 0;
    bus.inst_req = 1; bus.inst_addr = 32'h0000_3000;
    step();
    put_data(1'b1, 32'h0000_4000);
    step();
    step();
    bus.mem_addr_ok = 1;
    step();
    step();
    drain();

    // Fill to capacity, then responses free slots while a fifth request waits.
    bus.mem_addr_ok = 1;
    for (int i = 0; i < 5; i++) begin
      put_data(1'b1, 32'h0000_5000 + 32'(i * 4));
      step();
    end
    bus.mem_data_ok = 1;
    for (int i = 0; i < 4; i++) step();
    bus.mem_addr_ok = 0;
    drain();

    // Interleaved inst/data/inst, responses return in issue order.
    bus.mem_addr_ok = 1;
    bus.inst_req = 1; bus.inst_addr = 32'h0000_6000; step();
    put_data(1'b0, 32'h0000_6004); step();
    bus.inst_req = 1; bus.inst_addr = 32'h0000_6008; step();
    bus.mem_addr_ok = 0;
    bus.mem_data_ok = 1;
    for (int i = 0; i < 3; i++) step();
    bus.mem_data_ok = 0;

    // Spurious response sets sticky err; reset mid-stream clears everything.
    bus.mem_data_ok = 1; step();
    bus.mem_data_ok = 0; step(); step();
    bus.mem_addr_ok = 1;
    bus.inst_req = 1; bus.inst_addr = 32'h0000_7000; step();
    put_data(1'b1, 32'h0000_7004); step();
    bus.mem_addr_ok = 0;
    reset = 1; step();
    reset = 0; bus.inst_req = 0; bus.data_req = 0;
    step();
    bus.mem_data_ok = 1; step();
    bus.mem_data_ok = 0; step();

    // Random traffic with held requests and occasional reset.
    for (int n = 0; n < 600; n++) begin
      if (!bus.inst_req && $urandom_range(0, 2) == 0) begin
        bus.inst_req = 1; bus.inst_addr = $urandom;
      end
      if (!bus.data_req && $urandom_range(0, 2) == 0) put_data(1'($urandom), $urandom);
      bus.mem_addr_ok = ($urandom_range(0, 3) != 0);
      bus.mem_data_ok = (tagq.size() > 0) ? 1'($urandom) : ($urandom_range(0, 99) == 0);
      bus.mem_rdata   = $urandom;
      reset = (n == 300);
      step();
      if (n == 300) begin
        bus.inst_req = 0; bus.data_req = 0;
      end
    end
    reset = 0;
    bus.inst_req = 0; bus.data_req = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
